// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed-bus RTC master.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddrSetup,
      StAddrStrb,
      StAddrHold,
      StData,
      StRecover
   } state_e;

   localparam logic [7:0] SCAN1_LO_DEF = 8'h21;
   localparam logic [7:0] SCAN1_HI_DEF = 8'h26;
   localparam logic [7:0] SCAN2_LO_DEF = 8'h41;
   localparam logic [7:0] SCAN2_HI_DEF = 8'h43;

   // {cs_n, a_d, rd_n, wr_n} with every strobe released
   localparam logic [3:0] CTRL_IDLE = 4'b1111;

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/rtc_scan_ptr.sv
// Two-window register address sequencer: LO1..HI1, LO2..HI2, then wrap.
module rtc_scan_ptr
   import rtc_bus_pkg::*;
#(
   parameter int unsigned   DW       = 8,
   parameter logic [DW-1:0] SCAN1_LO = DW'(SCAN1_LO_DEF),
   parameter logic [DW-1:0] SCAN1_HI = DW'(SCAN1_HI_DEF),
   parameter logic [DW-1:0] SCAN2_LO = DW'(SCAN2_LO_DEF),
   parameter logic [DW-1:0] SCAN2_HI = DW'(SCAN2_HI_DEF)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          advance,
   output logic [DW-1:0] addr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr <= SCAN1_LO;
      end else if (advance) begin
         if (addr == SCAN1_HI)      addr <= SCAN2_LO;
         else if (addr == SCAN2_HI) addr <= SCAN1_LO;
         else                       addr <= addr + DW'(1);
      end
   end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus master for a multiplexed address/data RTC: free-running register scan plus host writes.
// Optional build macro RTC_BCD_CHECK_EN adds a packed-BCD check on read data.
module rtc_bus_ctrl
   import rtc_bus_pkg::*;
#(
   parameter int unsigned   DW       = 8,
   parameter logic [DW-1:0] SCAN1_LO = DW'(SCAN1_LO_DEF),
   parameter logic [DW-1:0] SCAN1_HI = DW'(SCAN1_HI_DEF),
   parameter logic [DW-1:0] SCAN2_LO = DW'(SCAN2_LO_DEF),
   parameter logic [DW-1:0] SCAN2_HI = DW'(SCAN2_HI_DEF),
   parameter int unsigned   T_SETUP  = 2,
   parameter int unsigned   T_STRB   = 2,
   parameter int unsigned   T_HOLD   = 2,
   parameter int unsigned   T_DATA   = 6,
   parameter int unsigned   T_REC    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          wr_req,
   input  logic [DW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic [DW-1:0] ad_in,
   output logic [DW-1:0] ad_out,
   output logic          ad_oe,
   output logic          cs_n,
   output logic          a_d,
   output logic          rd_n,
   output logic          wr_n,
   output logic          rd_valid,
   output logic [DW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_bcd_err,
   output logic          busy
);

   localparam int unsigned TM1  = (T_SETUP > T_STRB) ? T_SETUP : T_STRB;
   localparam int unsigned TM2  = (T_HOLD > T_DATA) ? T_HOLD : T_DATA;
   localparam int unsigned TM3  = (TM1 > TM2) ? TM1 : TM2;
   localparam int unsigned TMAX = (TM3 > T_REC) ? TM3 : T_REC;
   localparam int unsigned CW   = $clog2(TMAX) + 1;

   state_e        state;
   logic [CW-1:0] cnt;
   logic          last;
   logic          is_wr;
   logic [DW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic [DW-1:0] scan_addr;

   rtc_scan_ptr #(
      .DW       (DW),
      .SCAN1_LO (SCAN1_LO),
      .SCAN1_HI (SCAN1_HI),
      .SCAN2_LO (SCAN2_LO),
      .SCAN2_HI (SCAN2_HI)
   ) u_scan_ptr (
      .clk     (clk),
      .reset   (reset),
      .advance (rd_valid),
      .addr    (scan_addr)
   );

   always_comb begin
      last = 1'b1;
      case (state)
         StAddrSetup: last = (cnt == CW'(T_SETUP - 1));
         StAddrStrb:  last = (cnt == CW'(T_STRB - 1));
         StAddrHold:  last = (cnt == CW'(T_HOLD - 1));
         StData:      last = (cnt == CW'(T_DATA - 1));
         StRecover:   last = (cnt == CW'(T_REC - 1));
         default:     last = 1'b1;
      endcase
   end

   assign busy = (state != StIdle);

   // Outputs are registered: each transition loads the strobe pattern of the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                  <= StIdle;
         cnt                    <= '0;
         is_wr                  <= 1'b0;
         addr_q                 <= '0;
         data_q                 <= '0;
         {cs_n, a_d, rd_n, wr_n} <= CTRL_IDLE;
         ad_oe                  <= 1'b0;
         ad_out                 <= '0;
         wr_ack                 <= 1'b0;
         rd_valid               <= 1'b0;
         rd_addr                <= '0;
         rd_data                <= '0;
      end else begin
         wr_ack   <= 1'b0;
         rd_valid <= 1'b0;
         if (state != StIdle && !last) cnt <= cnt + CW'(1);
         case (state)
            StIdle: begin
               if (!hold) begin
                  state <= StAddrSetup;
                  cnt   <= '0;
                  cs_n  <= 1'b0;
                  ad_oe <= 1'b1;
                  if (wr_req) begin
                     is_wr  <= 1'b1;
                     addr_q <= wr_addr;
                     data_q <= wr_data;
                     ad_out <= wr_addr;
                  end else begin
                     is_wr  <= 1'b0;
                     addr_q <= scan_addr;
                     ad_out <= scan_addr;
                  end
               end
            end
            StAddrSetup: if (last) begin
               state <= StAddrStrb;
               cnt   <= '0;
               a_d   <= 1'b0;
            end
            StAddrStrb: if (last) begin
               state <= StAddrHold;
               cnt   <= '0;
               a_d   <= 1'b1;
            end
            StAddrHold: if (last) begin
               state <= StData;
               cnt   <= '0;
               if (is_wr) begin
                  ad_out <= data_q;
                  wr_n   <= 1'b0;
                  wr_ack <= (T_DATA == 1);
               end else begin
                  ad_oe <= 1'b0;
                  rd_n  <= 1'b0;
               end
            end
            StData: begin
               if (last) begin
                  state                  <= StRecover;
                  cnt                    <= '0;
                  {cs_n, a_d, rd_n, wr_n} <= CTRL_IDLE;
                  ad_oe                  <= 1'b0;
                  if (!is_wr) begin
                     rd_valid <= 1'b1;
                     rd_addr  <= addr_q;
                     rd_data  <= ad_in;
                  end
               end else if (is_wr && cnt == CW'(T_DATA - 2)) begin
                  wr_ack <= 1'b1;
               end
            end
            StRecover: if (last) begin
               state <= StIdle;
               cnt   <= '0;
            end
            default: begin
               state <= StIdle;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef RTC_BCD_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bcd_err <= 1'b0;
      end else if (state == StData && last && !is_wr) begin
         rd_bcd_err <= !is_bcd(8'(ad_in));
      end
   end
`else
   assign rd_bcd_err = 1'b0;
`endif

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
Parametrised bus master for a multiplexed-address/data RTC chip. The chip is reached through active-low CS/RD/WR strobes, an address-strobe line A/D and a shared AD bus. It free-runs a two-window register scan (date and time registers) with programmable phase timing, and adds host-initiated writes with a request/acknowledge handshake. It sits between the RTC pins and the formatting/display logic, and delivers each register read as a one-cycle valid pulse.

Parameters:
DW, 8, AD bus and data width
SCAN1_LO, 8'h21, first address of scan window 1
SCAN1_HI, 8'h26, last address of scan window 1
SCAN2_LO, 8'h41, first address of scan window 2
SCAN2_HI, 8'h43, last address of scan window 2
T_SETUP, 2, address setup cycles (>=1)
T_STRB, 2, A/D strobe-low cycles (>=1)
T_HOLD, 2, address hold cycles (>=1)
T_DATA, 6, RD/WR strobe-low cycles (>=1)
T_REC, 2, recovery cycles with CS high (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hold  in  1  pause request (OR of date/stime/timer edit modes); scan stops at a transaction boundary
wr_req  in  1  write request, level; held until wr_ack
wr_addr  in  DW  write register address
wr_data  in  DW  write data
wr_ack  out  1  one-cycle pulse, write completed
ad_in  in  DW  AD bus input
ad_out  out  DW  AD bus output value
ad_oe  out  1  AD bus output enable
cs_n  out  1  chip select, active low
a_d  out  1  address strobe, low = latch address
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
rd_valid  out  1  one-cycle pulse, read data valid
rd_addr  out  DW  address of the returned read
rd_data  out  DW  captured read data
rd_bcd_err  out  1  read data not valid packed BCD (optional feature)
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (async): state=IDLE, cs_n=a_d=rd_n=wr_n=1, ad_oe=0, ad_out=0, wr_ack=rd_valid=rd_bcd_err=0, rd_addr=rd_data=0, scan pointer=SCAN1_LO, phase counter=0. Reset mid-transaction aborts it immediately, without waiting for a clock edge.
- States: IDLE, ADDR_SETUP, ADDR_STRB, ADDR_HOLD, DATA, RECOVER. Each non-IDLE state lasts exactly its T_* cycles. The phase counter is $clog2(max T)+1 bits wide, cleared on every state entry.
- IDLE lasts 1 cycle and performs arbitration:
  - hold=1: stay in IDLE.
  - else wr_req=1: latch wr_addr and wr_data, mark the transaction as a write.
  - else: start a read of the scan pointer.
  - Writes have priority over the scan. Arbitration happens only in IDLE, so an in-flight transaction always completes.
- ADDR_SETUP/ADDR_STRB/ADDR_HOLD: cs_n=0, ad_oe=1, ad_out=transaction address. a_d=0 only in ADDR_STRB.
- DATA, read: ad_oe=0, rd_n=0. ad_in is sampled at the clock edge ending the last DATA cycle.
- DATA, write: ad_oe=1, ad_out=data, wr_n=0. wr_ack=1 during the last DATA cycle only.
- RECOVER: all strobes high, ad_oe=0.
  - For a read: rd_valid=1, rd_addr, rd_data and rd_bcd_err are presented in the first RECOVER cycle, and the scan pointer advances.
  - rd_addr and rd_data hold their values until the next read.
- Scan order: SCAN1_LO..SCAN1_HI, then SCAN2_LO..SCAN2_HI, then wrap to SCAN1_LO. Writes and hold never move the pointer.
- Read latency with defaults: cs_n falls in cycle 0, rd_valid appears in cycle 12, and the full transaction takes 15 cycles including IDLE.
- wr_req still high after wr_ack is treated as a new write at the next IDLE. The requester must drop wr_req within T_REC cycles of wr_ack.
- hold asserted and wr_req pending at the same time: hold wins, and the write waits.

Optional Feature:
RTC_BCD_CHECK_EN
- Defined: rd_bcd_err is registered alongside rd_data and is 1 when either nibble of the read data is greater than 9.
- Undefined: rd_bcd_err is tied to 0 and no check logic is built.

Decomposition:
- Package rtc_bus_pkg:
  - state enum
  - default SCAN_* address constants
  - control-idle constant (cs_n/a_d/rd_n/wr_n = 1111)
  - is_bcd function
- One natural sub-module, rtc_scan_ptr: the two-window address sequencer, with inputs advance and reset and output the current address.

Test Plan:
- Defaults, reset released, hold=0, ad_in=8'h59 -> cs_n low for 12 cycles; ad_out=8'h21 for 6 cycles; a_d low in cycles 2-3; rd_n low in cycles 6-11; rd_valid pulse in cycle 12 with rd_addr=8'h21 and rd_data=8'h59.
- Free-run 10 reads -> rd_addr sequence 21,22,23,24,25,26,41,42,43,21.
- wr_req with 8'h22/8'h15 raised during the read of 8'h23 -> 8'h23 read completes, then a write drives ad_out 8'h22 then 8'h15 with wr_n low 6 cycles and one wr_ack pulse; the next read is 8'h24.
- hold raised mid-transaction -> current transaction finishes, then cs_n stays high and busy=0; hold dropped -> scan resumes at the next unread address.
- reset asserted in DATA phase -> cs_n=rd_n=1 and ad_oe=0 before the next clk edge; after release the first read is 8'h21.
- With RTC_BCD_CHECK_EN: ad_in=8'h5A gives rd_bcd_err=1, ad_in=8'h59 gives 0. Without the macro: rd_bcd_err is always 0.
